// File: rtl/mux41_rr_collector_pkg.sv
// Shared types and constants for the four-to-one round-robin collector.
// FSM state encoding, source channel indices and burst counter width.
package mux41_rr_collector_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mux41_rr_collector_rr_pick4.sv
// Four-way round-robin picker: first requester after i_last_grant, cyclically.
// Ports: i_req (request vector), i_last_grant, o_winner, o_any_req.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last_grant,
    output logic [1:0] o_winner,
    output logic       o_any_req
);

    logic       w_found;
    logic [1:0] w_idx;

    // Scan offsets 1..4 so the previous winner is considered last.
    always_comb begin
        o_winner = i_last_grant;
        w_found  = 1'b0;
        w_idx    = i_last_grant;
        for (int k = 1; k <= 4; k++) begin
            w_idx = i_last_grant + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/mux41_rr_collector.sv
// Four-to-one collector: round-robin grant with burst lock, registered output.
// Ports: clk, reset, in_/valid_/ready_ a..d, out, out_valid, out_ready, out_select.
module mux41_rr_collector
    import mux41_rr_collector_pkg::*;
#(
    parameter int IO_WIDTH  = 8,
    parameter int BURST_LEN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IO_WIDTH-1:0] in_a,
    input  logic [IO_WIDTH-1:0] in_b,
    input  logic [IO_WIDTH-1:0] in_c,
    input  logic [IO_WIDTH-1:0] in_d,
    input  logic                valid_a,
    input  logic                valid_b,
    input  logic                valid_c,
    input  logic                valid_d,
    output logic                ready_a,
    output logic                ready_b,
    output logic                ready_c,
    output logic                ready_d,
    output logic [IO_WIDTH-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_select
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t              r_state;
    logic [1:0]          r_grant;
    logic [1:0]          r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [IO_WIDTH-1:0] r_out;
    logic                r_out_valid;
    logic [1:0]          r_out_sel;

    logic [3:0]          w_valid;
    logic [3:0]          w_ready;
    logic [1:0]          w_winner;
    logic                w_any;
    logic                w_valid_g;
    logic                w_can_take;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [IO_WIDTH-1:0] w_in_g;

    assign w_valid = {valid_d, valid_c, valid_b, valid_a};

    rr_pick4 u_pick (
        .i_req        (w_valid),
        .i_last_grant (r_last),
        .o_winner     (w_winner),
        .o_any_req    (w_any)
    );

    always_comb begin
        w_in_g = in_a;
        unique case (r_grant)
            CH_A:    w_in_g = in_a;
            CH_B:    w_in_g = in_b;
            CH_C:    w_in_g = in_c;
            CH_D:    w_in_g = in_d;
            default: w_in_g = in_a;
        endcase
    end

    // Output slot is free if empty or draining this very edge.
    assign w_can_take = !r_out_valid || out_ready;
    assign w_valid_g  = w_valid[r_grant];
    assign w_in_xfer  = (r_state == GRANT) && w_valid_g && w_can_take;
    assign w_out_xfer = r_out_valid && out_ready;

    assign w_ready = (r_state == GRANT && w_can_take)
                   ? (4'b0001 << r_grant) : 4'b0000;

    assign ready_a = w_ready[0];
    assign ready_b = w_ready[1];
    assign ready_c = w_ready[2];
    assign ready_d = w_ready[3];

    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign out_select = r_out_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= CH_A;
            r_last      <= CH_D;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= CH_A;
        end else begin
            if (w_in_xfer) begin
                r_out       <= w_in_g;
                r_out_sel   <= r_grant;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_in_xfer) begin
                        if (r_cnt == LAST_CNT) begin
                            r_last  <= r_grant;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (!w_valid_g) begin
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux41_rr_collector.sv
// Scoreboard bench for mux41_rr_collector with BURST_LEN 1 and 4 instances.
// Sources are modelled per channel; expected words are queued at stimulus time.
module tb_mux41_rr_collector;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ordy = 1'b1;
    logic       sel4 = 1'b0;
    logic       auto_inc = 1'b1;
    logic [3:0] vld = 4'b0;
    logic [7:0] din [4];

    logic [3:0] rdy1, rdy4, rdy;
    logic [7:0] out1, out4, dout;
    logic [1:0] osel1, osel4, osel;
    logic       ov1, ov4, ov;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   xcnt [4];
    exp_t sb [$];
    int   pop_t [$];
    exp_t m_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux41_rr_collector #(.IO_WIDTH(8), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .reset(rst),
        .in_a(din[0]), .in_b(din[1]), .in_c(din[2]), .in_d(din[3]),
        .valid_a(vld[0]), .valid_b(vld[1]),
        .valid_c(vld[2]), .valid_d(vld[3]),
        .ready_a(rdy1[0]), .ready_b(rdy1[1]),
        .ready_c(rdy1[2]), .ready_d(rdy1[3]),
        .out(out1), .out_valid(ov1), .out_ready(ordy),
        .out_select(osel1)
    );

    mux41_rr_collector #(.IO_WIDTH(8), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .reset(rst),
        .in_a(din[0]), .in_b(din[1]), .in_c(din[2]), .in_d(din[3]),
        .valid_a(vld[0]), .valid_b(vld[1]),
        .valid_c(vld[2]), .valid_d(vld[3]),
        .ready_a(rdy4[0]), .ready_b(rdy4[1]),
        .ready_c(rdy4[2]), .ready_d(rdy4[3]),
        .out(out4), .out_valid(ov4), .out_ready(ordy),
        .out_select(osel4)
    );

    assign rdy  = sel4 ? rdy4 : rdy1;
    assign dout = sel4 ? out4 : out1;
    assign osel = sel4 ? osel4 : osel1;
    assign ov   = sel4 ? ov4 : ov1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Output monitor: an output transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && ov && ordy && sb.size() > 0) begin
            m_e = sb.pop_front();
            check("out_data", 32'(dout), 32'(m_e.data));
            check("out_sel", 32'(osel), 32'(m_e.sel));
            pop_t.push_back(cyc);
        end
    end

    task automatic expect_word(input logic [1:0] s, input logic [7:0] d);
        exp_t e;
        e.sel  = s;
        e.data = d;
        sb.push_back(e);
    endtask

    // One clock; source channels advance their data after each accepted word.
    task automatic tick();
        logic [3:0] xf;
        @(negedge clk);
        xf = vld & rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (xf[i]) begin
                xcnt[i]++;
                if (auto_inc) din[i] = din[i] + 8'd1;
            end
        end
    endtask

    task automatic do_reset(input logic use4);
        rst  = 1'b1;
        vld  = 4'b0;
        ordy = 1'b1;
        sel4 = use4;
        tick();
        tick();
        sb.delete();
        pop_t.delete();
        for (int i = 0; i < 4; i++) xcnt[i] = 0;
        rst = 1'b0;
    endtask

    task automatic run_until(input int ch, input int n, input int budget);
        int k = 0;
        while (xcnt[ch] < n && k < budget) begin
            tick();
            k++;
        end
        check("xfer_wait", 32'(xcnt[ch] >= n), 32'd1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() > 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            din[i]  = 8'h00;
            xcnt[i] = 0;
        end

        // Reset state and single source
        do_reset(1'b0);
        rst = 1'b1;
        #1;
        check("rst_ov", 32'(ov1), 32'd0);
        check("rst_out", 32'(out1), 32'd0);
        check("rst_sel", 32'(osel1), 32'd0);
        check("rst_rdy", 32'(rdy1), 32'd0);
        rst = 1'b0;
        din[1] = 8'h5A;
        vld[1] = 1'b1;
        expect_word(2'b01, 8'h5A);
        tick();
        check("single_rdy", 32'(rdy), 32'b0010);
        tick();
        vld[1] = 1'b0;
        check("single_ov1", 32'(ov), 32'd1);
        check("single_out", 32'(dout), 32'h5A);
        tick();
        check("single_ov0", 32'(ov), 32'd0);
        check("single_rdy0", 32'(rdy), 32'd0);
        drain(5);

        // Four-way contention, constant source data
        do_reset(1'b0);
        auto_inc = 1'b0;
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        expect_word(2'b00, 8'h11);
        expect_word(2'b01, 8'h22);
        expect_word(2'b10, 8'h33);
        expect_word(2'b11, 8'h44);
        expect_word(2'b00, 8'h11);
        vld = 4'b1111;
        drain(40);
        check("rr_pops", 32'(pop_t.size()), 32'd5);
        if (pop_t.size() == 5)
            check("rr_span", 32'(pop_t[4] - pop_t[0]), 32'd8);
        auto_inc = 1'b1;

        // Backpressure
        do_reset(1'b0);
        ordy = 1'b0;
        din[0] = 8'hA1;
        vld[0] = 1'b1;
        expect_word(2'b00, 8'hA1);
        expect_word(2'b00, 8'hA2);
        tick();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_rdy", 32'(rdy), 32'd0);
            check("bp_out", 32'(dout), 32'hA1);
            check("bp_ov", 32'(ov), 32'd1);
            check("bp_sel", 32'(osel), 32'd0);
            tick();
        end
        ordy = 1'b1;
        #1;
        check("bp_rdy_rel", 32'(rdy), 32'b0001);
        tick();
        vld[0] = 1'b0;
        check("bp_swap_out", 32'(dout), 32'hA2);
        check("bp_swap_ov", 32'(ov), 32'd1);
        drain(5);

        // Burst of four, c and d continuous
        do_reset(1'b1);
        din[2] = 8'h30;
        din[3] = 8'h40;
        for (int i = 0; i < 4; i++) expect_word(2'b10, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) expect_word(2'b11, 8'h40 + 8'(i));
        expect_word(2'b10, 8'h34);
        vld = 4'b1100;
        drain(40);
        check("burst_pops", 32'(pop_t.size() >= 9), 32'd1);
        if (pop_t.size() >= 9) begin
            check("burst_c_run", 32'(pop_t[3] - pop_t[0]), 32'd3);
            check("burst_gap", 32'(pop_t[4] - pop_t[3]), 32'd2);
            check("burst_span", 32'(pop_t[8] - pop_t[0]), 32'd10);
        end

        // Early release with b waiting
        do_reset(1'b1);
        din[0] = 8'h50;
        din[1] = 8'h60;
        expect_word(2'b00, 8'h50);
        expect_word(2'b00, 8'h51);
        for (int i = 0; i < 4; i++) expect_word(2'b01, 8'h60 + 8'(i));
        vld = 4'b0011;
        run_until(0, 2, 20);
        vld[0] = 1'b0;
        run_until(1, 4, 30);
        vld[1] = 1'b0;
        drain(10);

        // Early release, a alone, then re-request
        do_reset(1'b1);
        din[0] = 8'h70;
        expect_word(2'b00, 8'h70);
        expect_word(2'b00, 8'h71);
        vld[0] = 1'b1;
        run_until(0, 2, 20);
        vld[0] = 1'b0;
        tick();
        tick();
        tick();
        check("rel_idle_rdy", 32'(rdy), 32'd0);
        expect_word(2'b00, 8'h72);
        expect_word(2'b00, 8'h73);
        vld[0] = 1'b1;
        run_until(0, 4, 20);
        vld[0] = 1'b0;
        drain(10);

        // Asynchronous reset mid-burst
        do_reset(1'b1);
        din[0] = 8'h80; din[1] = 8'h90; din[2] = 8'hA0; din[3] = 8'hB0;
        vld = 4'b1111;
        run_until(0, 2, 20);
        check("mid_ov", 32'(ov), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_ov", 32'(ov), 32'd0);
        check("ar_out", 32'(dout), 32'd0);
        check("ar_sel", 32'(osel), 32'd0);
        check("ar_rdy", 32'(rdy), 32'd0);
        tick();
        sb.delete();
        rst = 1'b0;
        expect_word(2'b00, din[0]);
        tick();
        check("ar_first_rdy", 32'(rdy), 32'b0001);
        drain(10);
        vld = 4'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
